sram_arbiter: RTL and testbench

Two-port arbiter in front of the `sram` controller; shares the single 256K×16 external SRAM between a high-priority port (port 0, video/pixel fetch) and a low-priority port (port 1, drawing/host access). It grants one complete read or write at a time and sequences the controller's `read`/`write`/`ready` handshake. It holds `address` and `data_write` stable for the full operation, because the controller passes the address through combinationally and latches write data one cycle after the command. A consecutive-grant limit keeps port 1 from starving.

---
 rtl/sram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Two-port arbiter in front of the single-port SRAM controller. Port 0
// (video fetch) has priority. Port 1 (drawing/host) is guaranteed service
// after MAX_BURST consecutive port-0 grants made while it was waiting.
// One complete read or write is in flight at a time. Address and write data
// are held from grant until the next grant, because the controller uses the
// address combinationally and samples write data one cycle after the command.
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata       : request from port N, held until pN_ack
//   pN_ack                     : one-cycle completion pulse
//   pN_rdata                   : read data, held until the next port-N read
//   sram_read / sram_write     : one-cycle command strobes to the controller
//   sram_address               : word address to the controller
//   sram_data_write            : write data to the controller
//   sram_data_read             : read data from the controller
//   sram_ready                 : controller idle / operation complete
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_write,
  input  logic [DATA_W-1:0] sram_data_read,
  input  logic              sram_ready
);

  localparam int unsigned       CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_port;   // port that owns the operation in flight
  logic             r_we;     // operation in flight is a write
  logic [CNT_W-1:0] r_burst;  // consecutive port-0 grants while port 1 waits

  logic w_p0_elig;
  logic w_p1_elig;
  logic w_pick1;
  logic w_grant;
  logic w_done;

  // The ack mask keeps a request that completes this cycle (and is still
  // asserted by its requester) from being granted a second time.
  assign w_p0_elig = p0_req & ~p0_ack;
  assign w_p1_elig = p1_req & ~p1_ack;
  assign w_pick1   = w_p1_elig & (~w_p0_elig | (r_burst == BURST_LIM));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    sram_read   = 1'b0;
    sram_write  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (sram_ready && (w_p0_elig || w_p1_elig)) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sram_read   = ~r_we;
        sram_write  = r_we;
        // Controller still reports idle in this cycle, so ready is not used.
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (sram_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_port          <= 1'b0;
      r_we            <= 1'b0;
      r_burst         <= '0;
      sram_address    <= '0;
      sram_data_write <= '0;
      p0_ack          <= 1'b0;
      p1_ack          <= 1'b0;
      p0_rdata        <= '0;
      p1_rdata        <= '0;
    end else begin
      r_state <= w_state_nxt;
      p0_ack  <= w_done & ~r_port;
      p1_ack  <= w_done & r_port;

      if (w_grant) begin
        r_port <= w_pick1;
        if (w_pick1) begin
          r_we            <= p1_we;
          sram_address    <= p1_addr;
          sram_data_write <= p1_wdata;
          r_burst         <= '0;
        end else begin
          r_we            <= p0_we;
          sram_address    <= p0_addr;
          sram_data_write <= p0_wdata;
          if (w_p1_elig) begin
            r_burst <= (r_burst == BURST_LIM) ? r_burst : r_burst + CNT_W'(1);
          end else begin
            r_burst <= '0;
          end
        end
      end

      if (w_done && !r_we) begin
        if (r_port) begin
          p1_rdata <= sram_data_read;
        end else begin
          p0_rdata <= sram_data_read;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level reference
// model. The bench also plays the SRAM controller (fixed 3-cycle response,
// optional idle stalls) and both requesters.
module tb_sram_arbiter;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req[2];
  logic          we[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic          p0_ack, p1_ack, sram_read, sram_write;
  logic [DW-1:0] p0_rdata, p1_rdata, sram_data_write;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_read = '0;
  logic          sram_ready = 1'b0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_address(sram_address), .sram_data_write(sram_data_write),
    .sram_data_read(sram_data_read), .sram_ready(sram_ready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // SRAM contents; unwritten words read back as an address-derived pattern.
  logic [DW-1:0] mem [int unsigned];

  // Controller model
  int            ctl_left = 0;
  int            gap_left = 0;
  int            gap_cfg  = 0;
  bit            gap_rand = 0;
  int            stall_pct = 0;
  logic          ctl_we;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wdata;
  int            cmds = 0;
  int            cmd_cyc = -1;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  // Requester models
  int rate[2]      = '{0, 0};
  bit done_flag[2] = '{0, 0};
  int acks[2]      = '{0, 0};
  int last_ack[2]  = '{-1, -1};
  int ack_order[$];

  // Reference model: an operation occupies the arbiter for 5 clock edges
  // from its grant; completion is visible in the cycle after the 4th edge.
  int            m_left = 0;
  int            m_burst = 0;
  int            m_port = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          e_ack[2] = '{1'b0, 1'b0};
  logic [DW-1:0] e_rdata[2] = '{'0, '0};
  logic          e_rd = 1'b0;
  logic          e_wr = 1'b0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic el0, el1, nack0, nack1;
    int w;
    if (reset) begin
      m_left = 0; m_burst = 0; m_addr = '0; m_wdata = '0;
      e_ack = '{1'b0, 1'b0}; e_rdata = '{'0, '0}; e_rd = 1'b0; e_wr = 1'b0;
      return;
    end
    el0 = req[0] && !e_ack[0];
    el1 = req[1] && !e_ack[1];
    nack0 = 1'b0; nack1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_port == 0) nack0 = 1'b1; else nack1 = 1'b1;
        if (!m_we) e_rdata[m_port] = mem_rd(m_addr);
      end
    end else if (sram_ready && (el0 || el1)) begin
      w = (el1 && (!el0 || m_burst == MB)) ? 1 : 0;
      if (w == 1) m_burst = 0;
      else if (el1) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
      else m_burst = 0;
      m_port = w; m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w];
      m_left = 4; e_rd = !m_we; e_wr = m_we;
    end
    e_ack[0] = nack0; e_ack[1] = nack1;
  endtask

  task automatic check_outputs();
    chk("sram_read", 32'(sram_read), 32'(e_rd));
    chk("sram_write", 32'(sram_write), 32'(e_wr));
    chk("sram_address", 32'(sram_address), 32'(m_addr));
    chk("sram_data_write", 32'(sram_data_write), 32'(m_wdata));
    chk("p0_ack", 32'(p0_ack), 32'(e_ack[0]));
    chk("p1_ack", 32'(p1_ack), 32'(e_ack[1]));
    chk("p0_rdata", 32'(p0_rdata), 32'(e_rdata[0]));
    chk("p1_rdata", 32'(p1_rdata), 32'(e_rdata[1]));
  endtask

  task automatic controller();
    sram_data_read = DW'($urandom);
    if (reset) begin
      ctl_left = 0; gap_left = 0; sram_ready = 1'b0;
    end else if (sram_read || sram_write) begin
      ctl_left = 3; gap_left = 0; cmds++; cmd_cyc = cyc;
      ctl_we = sram_write; ctl_addr = sram_address; ctl_wdata = sram_data_write;
      cmd_addr = sram_address; cmd_data = sram_data_write;
      sram_ready = 1'b1;
    end else if (ctl_left > 0) begin
      ctl_left--;
      if (ctl_left == 0) begin
        sram_ready = 1'b1;
        if (ctl_we) mem[32'(ctl_addr)] = ctl_wdata;
        else sram_data_read = mem_rd(ctl_addr);
        gap_left = gap_rand ? int'($urandom_range(2)) : gap_cfg;
      end else begin
        sram_ready = 1'b0;
      end
    end else if (gap_left > 0) begin
      gap_left--; sram_ready = 1'b0;
    end else begin
      sram_ready = ($urandom_range(99) >= stall_pct);
    end
  endtask

  task automatic new_req(input int p);
    req[p] = 1'b1; we[p] = 1'($urandom_range(1));
    addr[p] = AW'($urandom); wdata[p] = DW'($urandom);
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic requesters();
    logic ak;
    for (int p = 0; p < 2; p++) begin
      ak = (p == 0) ? p0_ack : p1_ack;
      if (done_flag[p]) begin
        done_flag[p] = 1'b0; req[p] = 1'b0;
      end
      if (!req[p] && rate[p] > 0 && int'($urandom_range(99)) < rate[p]) new_req(p);
      if (ak) begin
        done_flag[p] = 1'b1; acks[p]++; last_ack[p] = cyc; ack_order.push_back(p);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    controller();
    requesters();
  endtask

  task automatic wait_ack(input int p, input int budget, input string tag);
    int a0 = acks[p];
    int k = 0;
    while (acks[p] == a0 && k < budget) begin
      tick(); k++;
    end
    chk(tag, 32'(acks[p] != a0), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    rate = '{0, 0};
    while ((req[0] || req[1] || m_left > 0) && k < 60) begin
      tick(); k++;
    end
    chk("drain_timeout", 32'(req[0] || req[1] || m_left > 0), 32'd0);
    repeat (2) tick();
  endtask

  initial begin : main
    int t0, c0, a0, a1, rdy_cyc, k, n1;
    int exp_order[10];
    req = '{1'b0, 1'b0}; we = '{1'b0, 1'b0}; addr = '{'0, '0}; wdata = '{'0, '0};

    // Reset state
    repeat (3) tick();
    chk("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    chk("rst_sram_address", 32'(sram_address), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Port-0 read
    mem[32'h12] = 16'hBEEF;
    c0 = cmds; a1 = acks[1];
    set_req(0, 1'b0, 18'h00012, 16'h0000); t0 = cyc;
    wait_ack(0, 12, "rd_ack_timeout");
    chk("rd_latency", last_ack[0] - t0, 32'd5);
    chk("rd_cmd_cycle", cmd_cyc - t0, 32'd1);
    chk("rd_cmd_addr", 32'(cmd_addr), 32'h12);
    chk("rd_pulses", cmds - c0, 32'd1);
    chk("rd_p0_rdata", 32'(p0_rdata), 32'hBEEF);
    chk("rd_no_p1_ack", acks[1] - a1, 32'd0);
    repeat (2) tick();

    // Port-1 write
    c0 = cmds;
    set_req(1, 1'b1, 18'h3FFFF, 16'h1234); t0 = cyc;
    wait_ack(1, 12, "wr_ack_timeout");
    chk("wr_latency", last_ack[1] - t0, 32'd5);
    chk("wr_pulses", cmds - c0, 32'd1);
    chk("wr_cmd_data", 32'(cmd_data), 32'h1234);
    chk("wr_mem", 32'(mem_rd(18'h3FFFF)), 32'h1234);
    chk("wr_p1_rdata", 32'(p1_rdata), 32'd0);
    repeat (2) tick();

    // Simultaneous requests
    set_req(0, 1'b0, 18'h00100, 16'h0000);
    set_req(1, 1'b0, 18'h00200, 16'h0000); t0 = cyc;
    wait_ack(1, 20, "sim_ack_timeout");
    chk("sim_p0_first", last_ack[0] - t0, 32'd5);
    chk("sim_p1_after", last_ack[1] - last_ack[0], 32'd5);
    chk("sim_p1_rdata", 32'(p1_rdata), 32'(16'h0200 ^ 16'h5A5A));
    repeat (2) tick();

    // Starvation limit: the controller idles one cycle after each operation,
    // so both ports contend at every grant.
    gap_cfg = 1; rate = '{100, 100}; ack_order.delete();
    new_req(0); new_req(1);
    k = 0;
    while (ack_order.size() < 10 && k < 200) begin
      tick(); k++;
    end
    chk("burst_timeout", 32'(ack_order.size() >= 10), 32'd1);
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10 && i < ack_order.size(); i++)
      chk($sformatf("burst_order[%0d]", i), ack_order[i], exp_order[i]);
    drain();

    // Port 1 idle: port 0 is granted every time
    rate = '{100, 0}; ack_order.delete(); new_req(0);
    k = 0;
    while (ack_order.size() < 8 && k < 200) begin
      tick(); k++;
    end
    n1 = 0;
    foreach (ack_order[i]) if (ack_order[i] == 1) n1++;
    chk("p0only_count", 32'(ack_order.size() >= 8), 32'd1);
    chk("p0only_no_p1", n1, 32'd0);
    drain();
    gap_cfg = 0;

    // Controller not ready
    stall_pct = 100; tick();
    c0 = cmds;
    set_req(0, 1'b0, 18'h00055, 16'h0000);
    repeat (6) tick();
    chk("nr_no_cmd", cmds - c0, 32'd0);
    stall_pct = 0; tick(); rdy_cyc = cyc;
    wait_ack(0, 12, "nr_ack_timeout");
    chk("nr_grant", cmd_cyc - rdy_cyc, 32'd1);
    chk("nr_ack", last_ack[0] - rdy_cyc, 32'd5);
    repeat (2) tick();

    // Reset in WAIT of a port-0 read
    set_req(0, 1'b0, 18'h00077, 16'h0000); a0 = acks[0];
    k = 0;
    while (cmd_cyc != cyc && k < 10) begin
      tick(); k++;
    end
    chk("arst_cmd_seen", 32'(cmd_cyc == cyc), 32'd1);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_read", 32'(sram_read), 32'd0);
    chk("arst_write", 32'(sram_write), 32'd0);
    chk("arst_addr", 32'(sram_address), 32'd0);
    chk("arst_wdata", 32'(sram_data_write), 32'd0);
    chk("arst_acks", 32'({p0_ack, p1_ack}), 32'd0);
    chk("arst_p0_rdata", 32'(p0_rdata), 32'd0);
    chk("arst_p1_rdata", 32'(p1_rdata), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick(); rdy_cyc = cyc;
    chk("arst_no_ack", acks[0] - a0, 32'd0);
    wait_ack(0, 12, "arst_ack_timeout");
    chk("arst_fresh_latency", last_ack[0] - rdy_cyc, 32'd5);
    chk("arst_one_ack", acks[0] - a0, 32'd1);
    repeat (2) tick();

    // Random traffic
    c0 = cmds; a0 = acks[0] + acks[1];
    stall_pct = 20; gap_rand = 1; rate = '{40, 40};
    repeat (600) tick();
    stall_pct = 0; gap_rand = 0;
    drain();
    chk("rand_one_ack_per_grant", acks[0] + acks[1] - a0, cmds - c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
